// File: rtl/store_rmw_controller.sv
// store_rmw_controller: performs a byte/half/word store as a read-modify-write of the
// enclosing 64-bit doubleword; doubleword stores write directly without a read.
//
// Parameters:
//   MEM_LAT     memory read latency in cycles (1..15)
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 store request, sampled only while idle
//   funct3                store size: 0 sb, 1 sh, 2 sw, 3..7 sd
//   addr, store_data      byte address and register value of the store
//   mem_addr              doubleword-aligned memory address (0 while idle)
//   mem_rd / mem_rdata    one-cycle read strobe / read data (MEM_LAT cycles later)
//   mem_wr / mem_wdata    one-cycle write strobe / merged write data
//   busy, done, error     stall, completion pulse, misalignment pulse
//
// Optional feature: define STORE_MISALIGN_CHECK_EN to reject misaligned sh/sw/sd
// requests (one-cycle error pulse, no memory access). Without it, error is tied 0
// and misaligned addresses are truncated to the natural lane.
module store_rmw_controller #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  input  logic [63:0] mem_rdata,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef STORE_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
`endif

  state_t      state;
  logic [63:0] addr_q;
  logic [2:0]  f3_q;
  logic [63:0] data_q;
  logic [63:0] rdata_q;
  logic [3:0]  cnt_q;

  // Byte lane of the store inside the doubleword; low bits below the access size are dropped.
  function automatic logic [2:0] lane_off(input logic [2:0] f3, input logic [2:0] a);
    case (f3)
      3'd0:    lane_off = a;
      3'd1:    lane_off = {a[2:1], 1'b0};
      3'd2:    lane_off = {a[2], 2'b00};
      default: lane_off = 3'd0;
    endcase
  endfunction

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'd0:    size_bytes = 1;
      3'd1:    size_bytes = 2;
      3'd2:    size_bytes = 4;
      default: size_bytes = 8;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] base, input logic [63:0] data,
                                        input logic [2:0] f3, input logic [2:0] a);
    int          off;
    int          sz;
    logic [63:0] r;
    r   = base;
    off = int'(lane_off(f3, a));
    sz  = size_bytes(f3);
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + sz) r[i*8 +: 8] = data[(i-off)*8 +: 8];
    end
    return r;
  endfunction

`ifdef STORE_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    case (f3)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = a[0];
      3'd2:    misaligned = |a[1:0];
      default: misaligned = |a;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= addr;
            f3_q   <= funct3;
            data_q <= store_data;
            busy   <= 1'b1;
`ifdef STORE_MISALIGN_CHECK_EN
            if (misaligned(funct3, addr[2:0])) begin
              state <= ERR;
              error <= 1'b1;
            end else
`endif
            if (funct3 >= 3'd3) begin
              // Full doubleword: nothing to preserve, skip the read.
              state  <= WRITE;
              mem_wr <= 1'b1;
            end else begin
              state  <= READ;
              mem_rd <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WAIT;
          cnt_q <= 4'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= mem_rdata;
            state   <= WRITE;
            mem_wr  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          // start is deliberately not looked at here; acceptance resumes in IDLE.
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef STORE_MISALIGN_CHECK_EN
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic addr_active;
  assign addr_active = (state == READ) || (state == WAIT) || (state == WRITE) || (state == DONE);
  assign mem_addr    = addr_active ? {addr_q[63:3], 3'b000} : 64'd0;
  assign mem_wdata   = (f3_q >= 3'd3) ? data_q : merge(rdata_q, data_q, f3_q, addr_q[2:0]);

endmodule

// File: tb/tb_store_rmw_controller.sv
module tb_store_rmw_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start1, start3;
  logic [2:0]  funct3;
  logic [63:0] addr, store_data, mem_rdata;

  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_rd, a_wr, a_busy, a_done, a_err;
  logic        b_rd, b_wr, b_busy, b_done, b_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_rmw_controller #(.MEM_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .funct3(funct3), .addr(addr),
    .store_data(store_data), .mem_addr(a_addr), .mem_rd(a_rd), .mem_rdata(mem_rdata),
    .mem_wr(a_wr), .mem_wdata(a_wdata), .busy(a_busy), .done(a_done), .error(a_err)
  );

  store_rmw_controller #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .funct3(funct3), .addr(addr),
    .store_data(store_data), .mem_addr(b_addr), .mem_rd(b_rd), .mem_rdata(mem_rdata),
    .mem_wr(b_wr), .mem_wdata(b_wdata), .busy(b_busy), .done(b_done), .error(b_err)
  );

  // Sample point: 1 time unit after each rising edge. Cycle n = n-th edge counting the start edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start1 = 0; start3 = 0; funct3 = 0; addr = 0; store_data = 0; mem_rdata = 0;
    #3;
    vectors++;
    if ({a_busy, a_rd, a_wr, a_done, a_err} !== 5'b0 || a_addr !== 64'd0 || a_wdata !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_a: ctl=%b addr=%h wdata=%h, required 0/0/0",
               {a_busy, a_rd, a_wr, a_done, a_err}, a_addr, a_wdata);
    end
    vectors++;
    if ({b_busy, b_rd, b_wr, b_done, b_err} !== 5'b0 || b_addr !== 64'd0 || b_wdata !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_b: ctl=%b addr=%h wdata=%h, required 0/0/0",
               {b_busy, b_rd, b_wr, b_done, b_err}, b_addr, b_wdata);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // sb at 0x1003 on MEM_LAT=1, checked cycle by cycle; inputs scrambled after acceptance.
  task automatic test_sb_cycles();
    mem_rdata = 64'h1122334455667788;
    funct3 = 3'd0; addr = 64'h1003; store_data = 64'hAB; start1 = 1;
    tick();  // c1 READ
    start1 = 0; funct3 = 3'd3; addr = '1; store_data = '1;
    vectors++;
    if (a_rd !== 1'b1 || a_busy !== 1'b1 || a_addr !== 64'h1000) begin
      miscompares++;
      $display("FAIL sb_c1: rd=%b busy=%b addr=%h, required 1 1 1000", a_rd, a_busy, a_addr);
    end
    tick();  // c2 WAIT
    vectors++;
    if (a_rd !== 1'b0 || a_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_c2: rd=%b wr=%b, required 0 0", a_rd, a_wr);
    end
    tick();  // c3 WRITE
    vectors++;
    if (a_wr !== 1'b1 || a_wdata !== 64'h11223344AB667788 || a_addr !== 64'h1000 || a_done !== 0) begin
      miscompares++;
      $display("FAIL sb_c3: wr=%b wdata=%h addr=%h done=%b, required 1 11223344ab667788 1000 0",
               a_wr, a_wdata, a_addr, a_done);
    end
    tick();  // c4 DONE
    vectors++;
    if (a_done !== 1'b1 || a_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_c4: done=%b wr=%b, required 1 0", a_done, a_wr);
    end
    tick();  // c5 IDLE
    vectors++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_addr !== 64'd0) begin
      miscompares++;
      $display("FAIL sb_c5: busy=%b done=%b addr=%h, required 0 0 0", a_busy, a_done, a_addr);
    end
    settle();
  endtask

  // sw at 0x2004 with MEM_LAT=3: done 5 edges after the start edge (cycle 6).
  task automatic test_sw_lat3();
    int rd_cnt, wr_cnt, done_c;
    logic [63:0] wd;
    rd_cnt = 0; wr_cnt = 0; done_c = 0; wd = '0;
    mem_rdata = 64'd0;
    funct3 = 3'd2; addr = 64'h2004; store_data = 64'hDEADBEEF; start3 = 1;
    tick();
    start3 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (b_rd) rd_cnt++;
      if (b_wr) begin wr_cnt++; wd = b_wdata; end
      if (b_done && done_c == 0) done_c = c;
      tick();
    end
    vectors++;
    if (rd_cnt != 1 || wr_cnt != 1) begin
      miscompares++;
      $display("FAIL sw_strobes: rd=%0d wr=%0d, required 1 1", rd_cnt, wr_cnt);
    end
    vectors++;
    if (wd !== 64'hDEADBEEF00000000) begin
      miscompares++;
      $display("FAIL sw_wdata: got %h, required deadbeef00000000", wd);
    end
    vectors++;
    if (done_c != 6) begin
      miscompares++;
      $display("FAIL sw_done_cycle: got %0d, required 6", done_c);
    end
    settle();
  endtask

  task automatic test_sd();
    int rd_cnt;
    rd_cnt = 0;
    funct3 = 3'd3; addr = 64'h3000; store_data = 64'h0123456789ABCDEF; start1 = 1;
    tick();  // c1 WRITE
    start1 = 0;
    if (a_rd) rd_cnt++;
    vectors++;
    if (a_wr !== 1'b1 || a_wdata !== 64'h0123456789ABCDEF || a_addr !== 64'h3000) begin
      miscompares++;
      $display("FAIL sd_c1: wr=%b wdata=%h addr=%h, required 1 0123456789abcdef 3000",
               a_wr, a_wdata, a_addr);
    end
    tick();  // c2 DONE
    if (a_rd) rd_cnt++;
    vectors++;
    if (a_done !== 1'b1 || a_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL sd_c2: done=%b wr=%b, required 1 0", a_done, a_wr);
    end
    for (int c = 3; c <= 6; c++) begin
      tick();
      if (a_rd) rd_cnt++;
    end
    vectors++;
    if (rd_cnt != 0) begin
      miscompares++;
      $display("FAIL sd_no_read: rd pulses=%0d, required 0", rd_cnt);
    end
    settle();
  endtask

  task automatic test_merge_lanes();
    logic [2:0]  t_f3  [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
    logic [63:0] t_adr [4] = '{64'h1000, 64'h1006, 64'h1000, 64'h1008};
    logic [63:0] t_dat [4] = '{64'hCD, 64'h1234, 64'hFFFFFFFFA5A5A5A5, 64'hCAFEF00D12345678};
    logic [63:0] t_exp [4] = '{64'h11223344556677CD, 64'h1234334455667788,
                               64'h11223344A5A5A5A5, 64'hCAFEF00D12345678};
    logic [63:0] t_mad [4] = '{64'h1000, 64'h1000, 64'h1000, 64'h1008};
    mem_rdata = 64'h1122334455667788;
    for (int v = 0; v < 4; v++) begin
      logic        seen;
      logic [63:0] wd, wa;
      seen = 0; wd = '0; wa = '0;
      funct3 = t_f3[v]; addr = t_adr[v]; store_data = t_dat[v]; start1 = 1;
      tick();
      start1 = 0;
      for (int c = 1; c <= 8; c++) begin
        if (a_wr && !seen) begin seen = 1; wd = a_wdata; wa = a_addr; end
        tick();
      end
      vectors++;
      if (!seen || wd !== t_exp[v] || wa !== t_mad[v]) begin
        miscompares++;
        $display("FAIL merge_%0d: wr_seen=%b wdata=%h addr=%h, required 1 %h %h",
                 v, seen, wd, wa, t_exp[v], t_mad[v]);
      end
      settle();
    end
  endtask

  task automatic test_misalign();
    int rd_cnt, wr_cnt, err_cnt;
    logic done_seen;
    logic [63:0] wd;
    rd_cnt = 0; wr_cnt = 0; err_cnt = 0; done_seen = 0; wd = '0;
    mem_rdata = 64'h1122334455667788;
    funct3 = 3'd1; addr = 64'h5; store_data = 64'hBEEF; start1 = 1;
    tick();
    start1 = 0;
`ifdef STORE_MISALIGN_CHECK_EN
    vectors++;
    if (a_err !== 1'b1 || a_rd !== 1'b0 || a_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_c1: err=%b rd=%b wr=%b, required 1 0 0", a_err, a_rd, a_wr);
    end
    tick();
    vectors++;
    if (a_err !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_c2: err=%b busy=%b, required 0 0", a_err, a_busy);
    end
    for (int c = 3; c <= 8; c++) begin
      if (a_rd) rd_cnt++;
      if (a_wr) wr_cnt++;
      tick();
    end
    vectors++;
    if (rd_cnt != 0 || wr_cnt != 0) begin
      miscompares++;
      $display("FAIL misalign_noaccess: rd=%0d wr=%0d, required 0 0", rd_cnt, wr_cnt);
    end
`else
    for (int c = 1; c <= 8; c++) begin
      if (a_wr) begin wr_cnt++; wd = a_wdata; end
      if (a_err) err_cnt++;
      if (a_done) done_seen = 1;
      tick();
    end
    vectors++;
    if (wr_cnt != 1 || wd !== 64'h1122BEEF55667788 || !done_seen || err_cnt != 0) begin
      miscompares++;
      $display("FAIL misalign_trunc: wr=%0d wdata=%h done=%b err=%0d, required 1 1122beef55667788 1 0",
               wr_cnt, wd, done_seen, err_cnt);
    end
`endif
    settle();
  endtask

  // start re-pulsed in WAIT and held through DONE on MEM_LAT=3: only one write.
  task automatic test_back_to_back();
    int wr_cnt;
    wr_cnt = 0;
    mem_rdata = 64'd0;
    funct3 = 3'd0; addr = 64'h2001; store_data = 64'h77; start3 = 1;
    tick();                                  // c1 READ
    start3 = 0;
    tick();                                  // c2 WAIT
    start3 = 1;
    tick();                                  // c3 WAIT
    start3 = 0;
    tick();                                  // c4 WAIT
    tick();                                  // c5 WRITE
    if (b_wr) wr_cnt++;
    tick();                                  // c6 DONE
    vectors++;
    if (b_done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: done=%b, required 1", b_done);
    end
    start3 = 1;
    tick();                                  // c7 IDLE, start in DONE ignored
    vectors++;
    if (b_busy !== 1'b0 || b_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b rd=%b, required 0 0", b_busy, b_rd);
    end
    start3 = 0;
    for (int c = 8; c <= 18; c++) begin
      if (b_wr) wr_cnt++;
      tick();
    end
    vectors++;
    if (wr_cnt != 1) begin
      miscompares++;
      $display("FAIL b2b_writes: got %0d, required 1", wr_cnt);
    end
    settle();
  endtask

  task automatic test_reset_mid_write();
    logic        seen;
    logic [63:0] wd;
    int          done_c;
    seen = 0; wd = '0; done_c = 0;
    funct3 = 3'd3; addr = 64'h3000; store_data = 64'h5555; start1 = 1;
    tick();  // c1 WRITE
    start1 = 0;
    vectors++;
    if (a_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: wr=%b, required 1", a_wr);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (a_wr !== 1'b0 || a_busy !== 1'b0 || a_addr !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_async: wr=%b busy=%b addr=%h, required 0 0 0", a_wr, a_busy, a_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    vectors++;
    if (a_wr !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_retry: wr=%b busy=%b, required 0 0", a_wr, a_busy);
    end
    mem_rdata = 64'h1122334455667788;
    funct3 = 3'd0; addr = 64'h1003; store_data = 64'hAB; start1 = 1;
    tick();
    start1 = 0;
    for (int c = 1; c <= 8; c++) begin
      if (a_wr && !seen) begin seen = 1; wd = a_wdata; end
      if (a_done && done_c == 0) done_c = c;
      tick();
    end
    vectors++;
    if (!seen || wd !== 64'h11223344AB667788 || done_c != 4) begin
      miscompares++;
      $display("FAIL rst_recover: wr_seen=%b wdata=%h done_c=%0d, required 1 11223344ab667788 4",
               seen, wd, done_c);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_sb_cycles();
    test_sw_lat3();
    test_sd();
    test_merge_lanes();
    test_misalign();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
